mem_port_arbiter: RTL

- Shares the single unified instruction/data memory of the multicycle core between two requesters: the core's memory interface (requester 0, driven from the IorD/memread/memwrite path) and the program loader/debug port (requester 1).
- Serialises accesses with round-robin arbitration and runs a fixed-latency memory handshake.
- Returns read data and a one-cycle ready pulse to the winning requester; the core stalls its state machine until ready.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the core (requester 0)
// and the loader/debug port (requester 1); returns read data plus a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  // core requester
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ready,
  // loader requester
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic [DW-1:0] l_rdata,
  output logic          l_ready,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    gnt
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  logic          last_gnt;  // 1 = loader owned the previous grant
  logic          pick_l;

  // Loader wins only if the core is idle or the core was served last.
  always_comb begin
    pick_l = l_req && (!c_req || !last_gnt);
  end

  // The mem_* registers double as the latched request; they are zero outside ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      cnt       <= '0;
      last_gnt  <= 1'b1;
      gnt       <= 2'b00;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      c_rdata   <= '0;
      l_rdata   <= '0;
      c_ready   <= 1'b0;
      l_ready   <= 1'b0;
    end else begin
      c_ready <= 1'b0;
      l_ready <= 1'b0;
      unique case (state)
        StIdle: begin
          if (c_req || l_req) begin
            gnt       <= pick_l ? 2'b10 : 2'b01;
            last_gnt  <= pick_l;
            mem_en    <= 1'b1;
            mem_we    <= pick_l ? l_we : c_we;
            mem_addr  <= pick_l ? l_addr : c_addr;
            mem_wdata <= pick_l ? l_wdata : c_wdata;
            cnt       <= CW'(MEM_LAT - 1);
            state     <= StAccess;
          end
        end
        StAccess: begin
          if (cnt == '0) begin
            if (!mem_we) begin
              if (gnt[1]) l_rdata <= mem_rdata;
              else        c_rdata <= mem_rdata;
            end
            if (gnt[1]) l_ready <= 1'b1;
            else        c_ready <= 1'b1;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= StDone;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        StDone: begin
          gnt   <= 2'b00;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  a_ready_excl : assert property (@(posedge clk) disable iff (reset) !(c_ready && l_ready));
  a_en_owned   : assert property (@(posedge clk) disable iff (reset) mem_en |-> $onehot(gnt));

endmodule
